// File: rtl/tx_resp_scheduler.sv
// tx_resp_scheduler: queues ALU results (two bytes, LSB first) and register
// file read bytes in a small FIFO, then hands them one at a time to the UART
// TX synchronizer using a level-held valid / busy handshake.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   S_IDLE      | no byte in flight; launch the FIFO head when TX is not busy
//   S_WAIT_BUSY | valid held high, waiting for the UART to report busy
//   S_WAIT_DONE | UART accepted the byte; waiting for busy to fall again
module tx_resp_scheduler #(
    parameter int WIDTH         = 8,
    parameter int WIDTH_OUT_ALU = 16,
    parameter int DEPTH         = 8,
    parameter int BUSY_TIMEOUT  = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH_OUT_ALU-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    input  logic [WIDTH-1:0]         RF_RdData,
    input  logic                     RF_RdData_VLD,
    input  logic                     UART_TX_Busy,
    output logic [WIDTH-1:0]         UART_TX_DATA,
    output logic                     UART_TX_VLD,
    output logic                     OVF,
    output logic                     TO_ERR,
    output logic [$clog2(DEPTH):0]   PENDING
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    // Storage and pointers. Pointers carry one extra wrap bit so that a full
    // FIFO and an empty FIFO are distinguishable from the pointers alone.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Admission decode
    logic [CW-1:0]    free;
    logic [CW-1:0]    rf_room;
    logic             alu_ok;
    logic             rf_ok;
    logic [1:0]       push_n;
    logic             ovf_d;
    logic [AW-1:0]    idx_alu_lo;
    logic [AW-1:0]    idx_alu_hi;
    logic [AW-1:0]    idx_rf;

    // TX FSM
    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_d;
    logic             vld_d;
    logic             to_err_d;
    logic             pop;
    logic [TW-1:0]    tmr_q;
    logic [TW-1:0]    tmr_d;

    // Admission: decided purely on the start-of-cycle count, so a pop in the
    // same cycle never makes room. ALU is served first and is all-or-nothing;
    // RF gets whatever room the ALU push leaves behind.
    always_comb begin
        free       = CW'(DEPTH) - count;
        alu_ok     = ALU_OUT_VLD && (free >= CW'(2));
        rf_room    = alu_ok ? (free - CW'(2)) : free;
        rf_ok      = RF_RdData_VLD && (rf_room != '0);
        push_n     = {alu_ok, 1'b0} + {1'b0, rf_ok};
        ovf_d      = (ALU_OUT_VLD && !alu_ok) || (RF_RdData_VLD && !rf_ok);
        idx_alu_lo = wr_ptr[AW-1:0];
        idx_alu_hi = idx_alu_lo + AW'(1);
        idx_rf     = alu_ok ? (idx_alu_lo + AW'(2)) : idx_alu_lo;
    end

    // Byte storage writes; order in memory is ALU low, ALU high, RF byte.
    always_ff @(posedge CLK) begin
        if (alu_ok) begin
            mem[idx_alu_lo] <= ALU_OUT[WIDTH-1:0];
            mem[idx_alu_hi] <= ALU_OUT[2*WIDTH-1:WIDTH];
        end
        if (rf_ok) begin
            mem[idx_rf] <= RF_RdData[WIDTH-1:0];
        end
    end

    // Pointer and occupancy bookkeeping; the count register drives PENDING.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            OVF    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + CW'(push_n);
            rd_ptr <= rd_ptr + CW'(pop);
            count  <= count + CW'(push_n) - CW'(pop);
            OVF    <= ovf_d;
        end
    end

    assign PENDING = count;

    // TX handshake next-state and next-output decode. The busy timer is a
    // down-counter loaded on launch and checked for terminal count zero, so
    // valid stays high for exactly BUSY_TIMEOUT cycles before giving up.
    always_comb begin
        state_d  = state_q;
        data_d   = UART_TX_DATA;
        vld_d    = UART_TX_VLD;
        to_err_d = 1'b0;
        tmr_d    = tmr_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((count != '0) && !UART_TX_Busy) begin
                    data_d  = mem[rd_ptr[AW-1:0]];
                    vld_d   = 1'b1;
                    pop     = 1'b1;
                    tmr_d   = TW'(BUSY_TIMEOUT - 1);
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (UART_TX_Busy) begin
                    vld_d   = 1'b0;
                    state_d = S_WAIT_DONE;
                end else if (tmr_q == '0) begin
                    vld_d    = 1'b0;
                    to_err_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!UART_TX_Busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                vld_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // TX state, timer and registered outputs. Data only changes on a launch,
    // so it stays stable through the whole valid/busy window.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            UART_TX_DATA <= '0;
            UART_TX_VLD  <= 1'b0;
            TO_ERR       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            UART_TX_DATA <= data_d;
            UART_TX_VLD  <= vld_d;
            TO_ERR       <= to_err_d;
        end
    end

endmodule

// File: tb/tb_tx_resp_scheduler.sv
// Bench for tx_resp_scheduler: scoreboard of expected TX bytes fed by a model
// of the admission rules, a UART busy responder, and directed steps.
module tb_tx_resp_scheduler;

    localparam int DEPTH = 8;
    localparam int M_AUTO  = 0;
    localparam int M_HOLD  = 1;
    localparam int M_NEVER = 2;

    logic        clk;
    logic        rst;
    logic [15:0] alu_out;
    logic        alu_vld;
    logic [7:0]  rf_data;
    logic        rf_vld;
    wire         uart_tx_busy;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_vld;
    logic        ovf;
    logic        to_err;
    logic [3:0]  pending;

    int          rsp_mode;
    bit          rsp_rand;
    logic        rsp_busy;

    int          errors;
    int          checks;
    int          n_tx;
    logic [7:0]  exp_q[$];

    assign uart_tx_busy = (rsp_mode == M_HOLD)  ? 1'b1 :
                          (rsp_mode == M_NEVER) ? 1'b0 : rsp_busy;

    tx_resp_scheduler dut (
        .CLK           (clk),
        .RST           (rst),
        .ALU_OUT       (alu_out),
        .ALU_OUT_VLD   (alu_vld),
        .RF_RdData     (rf_data),
        .RF_RdData_VLD (rf_vld),
        .UART_TX_Busy  (uart_tx_busy),
        .UART_TX_DATA  (uart_tx_data),
        .UART_TX_VLD   (uart_tx_vld),
        .OVF           (ovf),
        .TO_ERR        (to_err),
        .PENDING       (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    // Drive one cycle of producer pulses; the model decides admission from
    // the number of bytes queued and not yet launched.
    task automatic drive(input bit a, input logic [15:0] av, input bit r,
                         input logic [7:0] rv, output int acc);
        int free;
        bit aok;
        bit rok;
        free = DEPTH - exp_q.size();
        aok  = a && (free >= 2);
        rok  = r && ((free - (aok ? 2 : 0)) >= 1);
        alu_out = av;
        alu_vld = a;
        rf_data = rv;
        rf_vld  = r;
        acc = 0;
        if (aok) begin
            exp_q.push_back(av[7:0]);
            exp_q.push_back(av[15:8]);
            acc += 2;
        end
        if (rok) begin
            exp_q.push_back(rv);
            acc += 1;
        end
        nxt();
        alu_vld = 1'b0;
        rf_vld  = 1'b0;
        check("ovf", {31'd0, ovf}, {31'd0, (a && !aok) || (r && !rok)});
        check("pending", {28'd0, pending}, exp_q.size());
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || uart_tx_vld || uart_tx_busy) && n < 3000) begin
            nxt();
            n++;
        end
        check({tag, "_drain_in_time"}, {31'd0, n < 3000}, 32'd1);
        nxt();
        nxt();
        check({tag, "_pending_zero"}, {28'd0, pending}, 32'd0);
    endtask

    // UART busy emulation: after valid is seen, wait a delay, then hold busy.
    initial begin : responder
        int d;
        int l;
        rsp_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_mode == M_AUTO && uart_tx_vld === 1'b1 && !rsp_busy) begin
                d = rsp_rand ? int'($urandom_range(1, 40)) : 1;
                l = rsp_rand ? int'($urandom_range(1, 8)) : 10;
                repeat (d - 1) @(negedge clk);
                rsp_busy = 1'b1;
                repeat (l) @(negedge clk);
                rsp_busy = 1'b0;
            end
        end
    end

    // Output monitor: every valid rise pops the scoreboard; data must hold
    // while valid or busy is high.
    initial begin : monitor
        logic       prev_vld;
        logic       win;
        logic [7:0] cap;
        logic [7:0] exp;
        prev_vld = 1'b0;
        win      = 1'b0;
        cap      = '0;
        forever begin
            @(negedge clk);
            if (uart_tx_vld === 1'b1 && prev_vld !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("tx_unexpected_byte", {24'd0, uart_tx_data}, 32'hFFFF_FFFF);
                end else begin
                    exp = exp_q.pop_front();
                    check("tx_data", {24'd0, uart_tx_data}, {24'd0, exp});
                end
                cap = uart_tx_data;
                win = 1'b1;
                n_tx++;
            end else if (win && (uart_tx_vld === 1'b1 || uart_tx_busy === 1'b1)) begin
                check("tx_data_hold", {24'd0, uart_tx_data}, {24'd0, cap});
            end
            if (uart_tx_vld !== 1'b1 && uart_tx_busy !== 1'b1) win = 1'b0;
            prev_vld = uart_tx_vld;
        end
    end

    initial begin : main
        int acc;
        int n;
        int accepted;
        int cyc;
        int base;
        int sel;
        errors   = 0;
        checks   = 0;
        n_tx     = 0;
        rsp_mode = M_NEVER;
        rsp_rand = 1'b0;
        rst      = 1'b1;
        alu_out  = '0;
        alu_vld  = 1'b0;
        rf_data  = '0;
        rf_vld   = 1'b0;

        // Power-on reset
        repeat (3) nxt();
        rst = 1'b0;
        check("por_vld", {31'd0, uart_tx_vld}, 32'd0);
        check("por_pending", {28'd0, pending}, 32'd0);
        check("por_ovf", {31'd0, ovf}, 32'd0);
        check("por_to_err", {31'd0, to_err}, 32'd0);
        check("por_data", {24'd0, uart_tx_data}, 32'd0);

        // Reset while a byte is in WAIT_BUSY
        drive(1'b0, 16'h0, 1'b1, 8'hAA, acc);
        drive(1'b0, 16'h0, 1'b1, 8'hBB, acc);
        check("rst_pre_vld", {31'd0, uart_tx_vld}, 32'd1);
        rst = 1'b1;
        nxt();
        check("rst_vld_same_edge", {31'd0, uart_tx_vld}, 32'd0);
        nxt();
        rst = 1'b0;
        exp_q.delete();
        nxt();
        check("rst_vld", {31'd0, uart_tx_vld}, 32'd0);
        check("rst_pending", {28'd0, pending}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_to_err", {31'd0, to_err}, 32'd0);

        // ALU result goes out LSB first; PENDING 2, 1, 0
        rsp_mode = M_AUTO;
        drive(1'b1, 16'hA55A, 1'b0, 8'h0, acc);
        check("alu_pending2", {28'd0, pending}, 32'd2);
        nxt();
        check("alu_pending1", {28'd0, pending}, 32'd1);
        wait_drain("alu");

        // Both producers in one cycle: 34, 12, C3
        drive(1'b1, 16'h1234, 1'b1, 8'hC3, acc);
        check("both_pending3", {28'd0, pending}, 32'd3);
        wait_drain("both");

        // Overflow with busy held: ALU dropped at 7, RF fills to 8, then full
        rsp_mode = M_HOLD;
        for (int i = 0; i < 7; i++) drive(1'b0, 16'h0, 1'b1, 8'h40 + 8'(i), acc);
        drive(1'b1, 16'hBEEF, 1'b0, 8'h0, acc);
        check("ovf_alu_pending7", {28'd0, pending}, 32'd7);
        drive(1'b0, 16'h0, 1'b1, 8'h77, acc);
        check("ovf_rf_pending8", {28'd0, pending}, 32'd8);
        drive(1'b0, 16'h0, 1'b1, 8'h88, acc);
        // Full FIFO with a pop in the same cycle still refuses the push
        rsp_mode = M_AUTO;
        drive(1'b0, 16'h0, 1'b1, 8'h99, acc);
        check("full_pop_pending7", {28'd0, pending}, 32'd7);
        wait_drain("ovf");

        // At 7 entries: ALU dropped, RF uses the last slot in the same cycle
        rsp_mode = M_HOLD;
        for (int i = 0; i < 7; i++) drive(1'b0, 16'h0, 1'b1, 8'h60 + 8'(i), acc);
        drive(1'b1, 16'hDEAD, 1'b1, 8'h5E, acc);
        check("split_pending8", {28'd0, pending}, 32'd8);
        rsp_mode = M_AUTO;
        wait_drain("split");

        // Busy timeout: valid held for BUSY_TIMEOUT cycles, then next byte
        rsp_mode = M_NEVER;
        drive(1'b0, 16'h0, 1'b1, 8'h11, acc);
        drive(1'b0, 16'h0, 1'b1, 8'h22, acc);
        n = 0;
        while (uart_tx_vld === 1'b1 && n < 400) begin
            n++;
            nxt();
        end
        check("to_vld_cycles", n, 32'd255);
        check("to_err_pulse", {31'd0, to_err}, 32'd1);
        nxt();
        check("to_err_clear", {31'd0, to_err}, 32'd0);
        check("to_next_vld", {31'd0, uart_tx_vld}, 32'd1);
        rsp_mode = M_AUTO;
        wait_drain("timeout");

        // Random busy delays over 200 bytes
        rsp_rand = 1'b1;
        base     = n_tx;
        accepted = 0;
        cyc      = 0;
        while (accepted < 200 && cyc < 20000) begin
            if (exp_q.size() <= DEPTH - 3 && $urandom_range(0, 2) == 0) begin
                sel = int'($urandom_range(0, 2));
                drive(sel != 1, 16'($urandom), sel != 0, 8'($urandom), acc);
                accepted += acc;
            end else begin
                nxt();
            end
            cyc++;
        end
        check("rand_in_budget", {31'd0, cyc < 20000}, 32'd1);
        wait_drain("rand");
        check("rand_byte_count", n_tx - base, accepted);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_resp_scheduler.md
# tx_resp_scheduler

Response scheduler between the REF_CLK-domain result producers (ALU and register file) and the UART transmit path. It buffers ALU results and register-file read data in a small byte FIFO. It then presents the bytes one at a time to the TX data synchronizer using a level-held valid/busy handshake, so no response is lost while the UART is still transmitting. The block sits in the REF_CLK domain and takes the already-synchronized TX busy flag.

## Interface
Parameters:
- WIDTH, 8, byte width of FIFO entries and of the TX data output
- WIDTH_OUT_ALU, 16, ALU result width; must equal 2*WIDTH
- DEPTH, 8, FIFO depth in bytes; power of two, at least 4
- BUSY_TIMEOUT, 255, maximum REF_CLK cycles to wait for UART_TX_Busy after raising valid

Ports:
- CLK  in  1  REF_CLK; the single clock of the block
- RST  in  1  synchronous, active-high reset
- ALU_OUT  in  WIDTH_OUT_ALU  ALU result
- ALU_OUT_VLD  in  1  one-cycle pulse; ALU_OUT is valid in that cycle
- RF_RdData  in  WIDTH  register-file read data
- RF_RdData_VLD  in  1  one-cycle pulse; RF_RdData is valid in that cycle
- UART_TX_Busy  in  1  UART transmitter busy, already synchronized to CLK
- UART_TX_DATA  out  WIDTH  byte presented to the TX synchronizer
- UART_TX_VLD  out  1  level-held request; held until busy is observed
- OVF  out  1  one-cycle pulse when a response is dropped because the FIFO is full
- TO_ERR  out  1  one-cycle pulse when a byte is abandoned after the busy timeout
- PENDING  out  $clog2(DEPTH)+1  number of bytes currently queued (FIFO occupancy)

## Operation
- **Reset:**
  - All outputs reset to 0.
  - FIFO pointers and count are cleared; the FSM goes to IDLE and the timeout counter clears.
  - A reset mid-transfer flushes the queue and drops UART_TX_VLD at that same edge.
- **Enqueue admission:**
  - Admission is evaluated against free = DEPTH - count, using the count at the start of the cycle. A same-cycle pop does not add space.
  - ALU is served first. It needs 2 free entries and pushes ALU_OUT[7:0] and then ALU_OUT[15:8] (LSB first).
  - RF is served second. It needs 1 entry out of what remains after the ALU push.
  - A producer without enough space is dropped whole; a partial ALU result is never queued.
  - OVF pulses if either producer is dropped in that cycle.
  - When both producers are accepted in the same cycle, the order is ALU low, ALU high, RF byte. Up to 3 writes per cycle are possible.
- **TX FSM** (states IDLE, WAIT_BUSY, WAIT_DONE):
  - IDLE: if count>0 and UART_TX_Busy=0, register the head byte into UART_TX_DATA, set UART_TX_VLD=1, pop the head, clear the timer, and go to WAIT_BUSY.
  - WAIT_BUSY: hold UART_TX_VLD=1 and keep the data stable.
    - If UART_TX_Busy=1: clear VLD and go to WAIT_DONE.
    - Else, if the timer reaches BUSY_TIMEOUT: clear VLD, pulse TO_ERR, and go to IDLE. The byte is discarded.
  - WAIT_DONE: when UART_TX_Busy=0, go to IDLE.
  - UART_TX_DATA stays constant from the VLD rise until the exit from WAIT_DONE.
- **Ordering:** bytes leave the block in strict FIFO order; there is no reordering between producers.
- **Occupancy:** PENDING = count after the push/pop of the current edge. It wraps modulo 2*DEPTH internally, with an extra pointer bit distinguishing full from empty.

## Timing
- All outputs are registered.
- **Enqueue:** a push at edge N is visible in PENDING after edge N.
- **Minimum latency, empty FIFO with Busy=0:**
  - A valid pulse is sampled at edge N.
  - FIFO is non-empty after edge N.
  - UART_TX_VLD=1 after edge N+1, so the byte is popped in the cycle after the push.
- **Timer:** the timer counts cycles spent in WAIT_BUSY. A timeout fires on the edge where the count equals BUSY_TIMEOUT.
- **Gap between bytes:** at least one IDLE cycle between WAIT_DONE exit and the next VLD rise.
- **Full FIFO with a simultaneous pop:** the push is still refused, because admission uses the start-of-cycle count.

## Test plan
- Reset state:
  - Assert RST for 2 cycles while VLD is high in WAIT_BUSY.
  - Expect on the next cycle: UART_TX_VLD=0, PENDING=0, OVF=0, TO_ERR=0.
- ALU result, LSB first:
  - Drive ALU_OUT=16'hA55A with a VLD pulse; emulate busy for 10 cycles per byte.
  - Expect TX bytes 8'h5A then 8'hA5, and PENDING sequence 2, 1, 0.
- Simultaneous producers:
  - Pulse ALU_OUT=16'h1234 and RF_RdData=8'hC3 in the same cycle.
  - Expect PENDING=3 and TX order 34, 12, C3.
- Overflow, with Busy held at 1:
  - Queue 7 RF bytes, then pulse ALU_OUT.
  - Expect OVF pulse, PENDING stays 7, and the ALU bytes never appear.
  - Then pulse RF.
  - Expect it is accepted (PENDING=8).
- Timeout, with BUSY_TIMEOUT=255 and Busy never asserted:
  - Expect VLD held high for 255 cycles, then a TO_ERR pulse.
  - Expect the byte discarded and the next byte presented afterward.
- Handshake stability:
  - Randomize the busy response delay between 1 and 40 cycles over 200 bytes.
  - Expect UART_TX_DATA stable throughout each VLD/busy window, no byte lost, and order preserved.
